// File: rtl/order_pkg.sv
// Shared order-message definitions used by the payload parser and the order book.
package order_pkg;

  localparam int unsigned MSG_BYTES  = 8;
  localparam int unsigned MSG_W      = MSG_BYTES * 8;
  localparam int unsigned ORDER_ID_W = 16;
  localparam int unsigned PRICE_W    = 16;
  localparam int unsigned QTY_W      = 16;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_ADD    = 2'd1,
    OP_CANCEL = 2'd2,
    OP_MODIFY = 2'd3
  } opcode_e;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  typedef struct packed {
    opcode_e                 opcode;
    logic                    side;
    logic [ORDER_ID_W-1:0]   order_id;
    logic [PRICE_W-1:0]      price;
    logic [QTY_W-1:0]        qty;
  } order_msg_t;

endpackage

// File: rtl/order_msg_checker.sv
// Combinational opcode/side validation and field slicing of an assembled message.
module order_msg_checker
  import order_pkg::*;
(
  input  logic [MSG_W-1:0] msg,
  output logic             msg_ok,
  output order_msg_t       fields
);

  logic [7:0] op_byte;
  logic [7:0] side_byte;

  assign op_byte   = msg[MSG_W-1 -: 8];
  assign side_byte = msg[MSG_W-9 -: 8];

  // Whole bytes are range-checked, so stray high bits reject the message.
  assign msg_ok = (op_byte >= 8'h01) && (op_byte <= 8'h03) && (side_byte <= 8'h01);

  always_comb begin
    fields          = '0;
    fields.opcode   = opcode_e'(op_byte[1:0]);
    fields.side     = side_byte[0];
    fields.order_id = msg[47:32];
    fields.price    = msg[31:16];
    fields.qty      = msg[15:0];
  end

endmodule

// File: rtl/order_msg_parser.sv
// Frames UDP payload bytes from a non-FWFT FIFO into 8-byte order messages and
// presents validated, decoded fields over valid/ready; idle timeout realigns.
module order_msg_parser #(
  parameter int unsigned MSG_BYTES      = order_pkg::MSG_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         fifo_dout,
  input  logic                               fifo_empty,
  output logic                               fifo_rd_en,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [1:0]                         m_opcode,
  output logic                               m_side,
  output logic [order_pkg::ORDER_ID_W-1:0]   m_order_id,
  output logic [order_pkg::PRICE_W-1:0]      m_price,
  output logic [order_pkg::QTY_W-1:0]        m_qty,
  output logic [CNT_W-1:0]                   msg_cnt,
  output logic [CNT_W-1:0]                   bad_msg_cnt,
  output logic [CNT_W-1:0]                   resync_cnt
);

  import order_pkg::order_msg_t;

  localparam int unsigned MSG_W = MSG_BYTES * 8;
  localparam int unsigned CW    = $clog2(MSG_BYTES + 1);
  localparam int unsigned IW    = $clog2(MSG_BYTES);
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES);

  localparam logic [CW-1:0] FULL      = CW'(MSG_BYTES);
  localparam logic [CW-1:0] LAST      = CW'(MSG_BYTES - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {ST_COLLECT, ST_EMIT} state_e;

  state_e          state, state_d;
  logic [CW-1:0]   issued, issued_d;
  logic [CW-1:0]   received, received_d;
  logic [TW-1:0]   timer, timer_d;
  logic            rd_vld;
  logic [7:0]      asm_q [MSG_BYTES];
  logic [7:0]      asm_d [MSG_BYTES];
  logic [MSG_W-1:0] msg_flat;
  logic            chk_ok;
  order_msg_t      chk_fields;
  order_msg_t      out_q;
  logic            load_msg, inc_msg, inc_bad, inc_resync;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The checker sees the message including the byte landing this cycle, so a
  // completed message is judged on the same cycle as the rd_vld of its last byte.
  always_comb begin
    asm_d = asm_q;
    if (rd_vld) asm_d[received[IW-1:0]] = fifo_dout;
    msg_flat = '0;
    for (int i = 0; i < int'(MSG_BYTES); i++) msg_flat[MSG_W-1-8*i -: 8] = asm_d[i];
  end

  order_msg_checker u_checker (
    .msg    (msg_flat),
    .msg_ok (chk_ok),
    .fields (chk_fields)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state;
    issued_d   = issued;
    received_d = received;
    timer_d    = timer;
    fifo_rd_en = 1'b0;
    load_msg   = 1'b0;
    inc_msg    = 1'b0;
    inc_bad    = 1'b0;
    inc_resync = 1'b0;

    case (state)
      ST_COLLECT: begin
        fifo_rd_en = !rst && !fifo_empty && (issued < FULL);
        if (fifo_rd_en) issued_d = issued + 1'b1;

        if (rd_vld) begin
          received_d = received + 1'b1;
          timer_d    = '0;
          if (received == LAST) begin
            issued_d   = '0;
            received_d = '0;
            if (chk_ok) begin
              load_msg = 1'b1;
              state_d  = ST_EMIT;
            end else begin
              inc_bad = 1'b1;
            end
          end
        end else if (received == '0) begin
          timer_d = '0;
        end else if ((issued == received) && !fifo_rd_en) begin
          // Nothing in flight and nothing arriving: a truncated payload ages out.
          if (timer == TIMER_MAX) begin
            issued_d   = '0;
            received_d = '0;
            timer_d    = '0;
            inc_resync = 1'b1;
          end else begin
            timer_d = timer + 1'b1;
          end
        end
      end

      ST_EMIT: begin
        if (m_ready) begin
          inc_msg = 1'b1;
          state_d = ST_COLLECT;
        end
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_COLLECT;
      issued      <= '0;
      received    <= '0;
      timer       <= '0;
      rd_vld      <= 1'b0;
      out_q       <= '0;
      msg_cnt     <= '0;
      bad_msg_cnt <= '0;
      resync_cnt  <= '0;
    end else begin
      state    <= state_d;
      issued   <= issued_d;
      received <= received_d;
      timer    <= timer_d;
      rd_vld   <= fifo_rd_en;
      if (load_msg)   out_q       <= chk_fields;
      if (inc_msg)    msg_cnt     <= sat_inc(msg_cnt);
      if (inc_bad)    bad_msg_cnt <= sat_inc(bad_msg_cnt);
      if (inc_resync) resync_cnt  <= sat_inc(resync_cnt);
    end
  end

  // NOTE: the assembly bytes are not reset; received gates every use of them.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  assign m_valid    = (state == ST_EMIT);
  assign m_opcode   = out_q.opcode;
  assign m_side     = out_q.side;
  assign m_order_id = out_q.order_id;
  assign m_price    = out_q.price;
  assign m_qty      = out_q.qty;

endmodule
